conv_row_engine: RTL and testbench
==================================

// Module: conv_row_engine
// PURPOSE
// - Downstream consumer of the row buffer: takes OUT_NUM_OF_SET rows (dout/valid), computes a KH x KW convolution along the row.
// - Produces NUM_OUT = DATA_OF_SET-KW+1 window sums (126 by default), LANES per beat; results go to the accumulate/writeback stage.
// - Rows are buffered internally, so the buffer may advance once capture has happened.
// PARAMETERS
// - DATA_WIDTH     32   signed element/weight width
// - DATA_OF_SET    128  elements per row
// - OUT_NUM_OF_SET 3    rows per window (kernel height KH)
// - KERNEL_W       3    kernel width KW
// - LANES          14   windows computed per beat; must divide NUM_OUT (elaboration $error otherwise)
// - ACC_WIDTH      2*DATA_WIDTH+$clog2(KH*KW)  result width
// PORTS
// - clk        in   1                      clock
// - rst        in   1                      reset, asynchronous, active-high
// - row_din    in   [KH][DATA_OF_SET][DW]  rows from buffer dout
// - row_valid  in   [KH]                   per-row valid from buffer
// - weight_wen in   1                      load kernel (honoured only when idle)
// - weight_din in   [KH][KW][DW]           kernel coefficients
// - res_ready  in   1                      downstream accepts res_dout
// - res_dout   out  [LANES][ACC_WIDTH]     window sums for this beat
// - res_valid  out  1                      res_dout valid
// - res_beat   out  $clog2(NUM_BEATS)      beat index; window = beat*LANES+lane
// - done       out  1                      one-cycle pulse on acceptance of the last beat
// - busy       out  1                      state != IDLE
// - overrun    out  1                      sticky: rows arrived while busy, or weight_wen while busy
// BEHAVIOUR
// - Reset, async active-high: state=IDLE; res_dout=0; res_valid=0; res_beat=0; done=0; busy=0; overrun=0.
// - Reset also clears weights and the row regs to 0 and clears all_valid_q.
// - all_valid = &row_valid. Capture event = all_valid & ~all_valid_q (rising edge only).
//   - A held valid does not re-capture. Partial valid is ignored.
// - States: IDLE, COMPUTE.
// - IDLE: on a capture event, latch row_din, set beat=0, go to COMPUTE. busy rises the next cycle.
// - COMPUTE: each cycle with !res_valid | res_ready, register beat b.
//   - res_dout[l] = sum over r<KH, k<KW of row[r][b*LANES+l+k] * w[r][k], full-precision signed.
//   - res_valid=1; res_beat=b; b++.
// - Latency: capture edge E; beat 0 visible after edge E+1. With res_ready=1, one beat per cycle.
// - Backpressure: res_valid=1 & res_ready=0 holds res_dout/res_beat stable. No beat is skipped or repeated.
// - Last beat (b=NUM_BEATS-1) accepted: done=1 for one cycle.
//   - A capture event in that same cycle restarts COMPUTE with the new rows, no bubble. Otherwise go to IDLE.
// - A capture event in COMPUTE other than on last-beat acceptance sets overrun and drops the rows.
// - weight_wen in IDLE: weights load at the edge. In COMPUTE: ignored, overrun set.
//   - weight_wen and a capture event in the same IDLE cycle: new weights apply to that capture.
// - res_valid clears after a beat is accepted with no further beat to issue.
// - overrun clears only on rst.
// - Mid-operation rst: immediate abort, no done pulse.
// CONFIGURATION
// - CONV_ROW_ENGINE_RELU_EN defined: negative sums are clamped to 0 before registering res_dout.
// - Undefined: raw signed sums.
// - Control timing is identical either way.
// STRUCTURE
// - Package conv_pkg:
//   - state enum conv_state_e {IDLE, COMPUTE}
//   - NUM_OUT and NUM_BEATS localparam functions
//   - acc_width() helper
//   - row/kernel packed typedefs shared with the buffer
// - Sub-module conv_mac_lane: one KH x KW dot product, combinational, instantiated LANES times via generate.
// TESTING
// - Ramp rows row[r][i]=i, all weights=1, res_ready=1 -> 9 beats on consecutive cycles.
//   - Window j = 9j+9. Beat 0 lane 0 = 9. done with beat 8.
// - Mid-beat res_ready=0 for 3 cycles -> res_dout/res_beat held. Total 9 beats, no duplicates.
// - Capture on the last-beat acceptance cycle -> beat 0 of the new rows on the next cycle, busy stays 1.
// - Capture at beat 3 -> overrun=1, current results unchanged. weight_wen while busy -> overrun=1, weights unchanged.
// - row_valid held at 3'b111 after done -> no second run. row_valid=3'b011 -> no capture.
// - Weights w[1][1]=-1, others 0, rows=5 -> all sums -5, or 0 with CONV_ROW_ENGINE_RELU_EN.
//   - rst at beat 4 -> all outputs 0 at once.

Source files
------------

// File: rtl/conv_row_engine_pkg.sv
// Shared types and sizing helpers for the row convolution engine and its row buffer.
package conv_pkg;

   typedef enum logic [0:0] {IDLE = 1'b0, COMPUTE = 1'b1} conv_state_e;

   localparam int DEF_DATA_WIDTH  = 32;
   localparam int DEF_DATA_OF_SET = 128;
   localparam int DEF_KH          = 3;
   localparam int DEF_KW          = 3;

   function automatic int num_out(input int data_of_set, input int kw);
      return data_of_set - kw + 1;
   endfunction

   function automatic int num_beats(input int data_of_set, input int kw, input int lanes);
      return num_out(data_of_set, kw) / lanes;
   endfunction

   // Sum of KH*KW full-width products never overflows this width.
   function automatic int acc_width(input int dw, input int kh, input int kw);
      return 2 * dw + $clog2(kh * kw);
   endfunction

   function automatic int beat_w(input int nb);
      return (nb > 1) ? $clog2(nb) : 1;
   endfunction

   typedef logic [DEF_KH-1:0][DEF_DATA_OF_SET-1:0][DEF_DATA_WIDTH-1:0] row_set_t;
   typedef logic [DEF_KH-1:0][DEF_KW-1:0][DEF_DATA_WIDTH-1:0]          kernel_t;

endpackage

// File: rtl/conv_row_engine_if.sv
// Row-in / result-out bundle of the convolution engine; master is the buffer/writeback side.
interface conv_row_engine_if
   import conv_pkg::*;
#(
   parameter int DATA_WIDTH     = DEF_DATA_WIDTH,
   parameter int DATA_OF_SET    = DEF_DATA_OF_SET,
   parameter int OUT_NUM_OF_SET = DEF_KH,
   parameter int KERNEL_W       = DEF_KW,
   parameter int LANES          = 14
);
   localparam int NUM_BEATS = num_beats(DATA_OF_SET, KERNEL_W, LANES);
   localparam int ACC_WIDTH = acc_width(DATA_WIDTH, OUT_NUM_OF_SET, KERNEL_W);
   localparam int BEAT_W    = beat_w(NUM_BEATS);

   logic [OUT_NUM_OF_SET-1:0][DATA_OF_SET-1:0][DATA_WIDTH-1:0] row_din;
   logic [OUT_NUM_OF_SET-1:0]                                  row_valid;
   logic                                                       weight_wen;
   logic [OUT_NUM_OF_SET-1:0][KERNEL_W-1:0][DATA_WIDTH-1:0]    weight_din;
   logic                                                       res_ready;
   logic [LANES-1:0][ACC_WIDTH-1:0]                            res_dout;
   logic                                                       res_valid;
   logic [BEAT_W-1:0]                                          res_beat;
   logic                                                       done;
   logic                                                       busy;
   logic                                                       overrun;

   modport master (
      output row_din, row_valid, weight_wen, weight_din, res_ready,
      input  res_dout, res_valid, res_beat, done, busy, overrun
   );

   modport slave (
      input  row_din, row_valid, weight_wen, weight_din, res_ready,
      output res_dout, res_valid, res_beat, done, busy, overrun
   );
endinterface

// File: rtl/conv_row_engine_mac_lane.sv
// One KH x KW signed dot product, purely combinational, full precision.
module conv_mac_lane
   import conv_pkg::*;
#(
   parameter int DATA_WIDTH = DEF_DATA_WIDTH,
   parameter int KH         = DEF_KH,
   parameter int KW         = DEF_KW,
   parameter int ACC_WIDTH  = acc_width(DATA_WIDTH, KH, KW)
) (
   input  logic [KH-1:0][KW-1:0][DATA_WIDTH-1:0] win,
   input  logic [KH-1:0][KW-1:0][DATA_WIDTH-1:0] w,
   output logic signed [ACC_WIDTH-1:0]           sum
);
   logic signed [2*DATA_WIDTH-1:0] prod;
   logic signed [ACC_WIDTH-1:0]    acc;

   always_comb begin
      prod = '0;
      acc  = '0;
      for (int r = 0; r < KH; r++) begin
         for (int k = 0; k < KW; k++) begin
            prod = $signed(win[r][k]) * $signed(w[r][k]);
            acc  = acc + ACC_WIDTH'(prod);
         end
      end
      sum = acc;
   end
endmodule

// File: rtl/conv_row_engine.sv
// Row convolution engine: captures KH rows, streams NUM_OUT window sums LANES per beat.
// Optional CONV_ROW_ENGINE_RELU_EN clamps negative sums to zero before they are registered.
module conv_row_engine
   import conv_pkg::*;
#(
   parameter int DATA_WIDTH     = DEF_DATA_WIDTH,
   parameter int DATA_OF_SET    = DEF_DATA_OF_SET,
   parameter int OUT_NUM_OF_SET = DEF_KH,
   parameter int KERNEL_W       = DEF_KW,
   parameter int LANES          = 14
) (
   input logic               clk,
   input logic               rst,
   conv_row_engine_if.slave  bus
);
   localparam int KH        = OUT_NUM_OF_SET;
   localparam int KW        = KERNEL_W;
   localparam int NUM_OUT   = num_out(DATA_OF_SET, KW);
   localparam int NUM_BEATS = num_beats(DATA_OF_SET, KW, LANES);
   localparam int ACC_WIDTH = acc_width(DATA_WIDTH, KH, KW);
   localparam int BEAT_W    = beat_w(NUM_BEATS);
   localparam int CNT_W     = $clog2(NUM_BEATS + 1);
   localparam int IDX_W     = $clog2(DATA_OF_SET);

   if (NUM_OUT % LANES != 0) begin : g_bad_lanes
      $error("LANES (%0d) must divide NUM_OUT (%0d)", LANES, NUM_OUT);
   end

   typedef logic [KH-1:0][DATA_OF_SET-1:0][DATA_WIDTH-1:0] rows_t;
   typedef logic [KH-1:0][KW-1:0][DATA_WIDTH-1:0]          kern_t;
   typedef logic [LANES-1:0][ACC_WIDTH-1:0]                res_t;

   function automatic logic signed [ACC_WIDTH-1:0] apply_relu(input logic signed [ACC_WIDTH-1:0] x);
`ifdef CONV_ROW_ENGINE_RELU_EN
      return x[ACC_WIDTH-1] ? '0 : x;
`else
      return x;
`endif
   endfunction

   conv_state_e       state_q, state_d;
   rows_t             rows_q, rows_d;
   kern_t             w_q, w_d;
   res_t              res_dout_q, res_dout_d;
   logic              res_valid_q, res_valid_d;
   logic [BEAT_W-1:0] res_beat_q, res_beat_d;
   logic [CNT_W-1:0]  beat_q, beat_d;
   logic              done_q, done_d;
   logic              overrun_q, overrun_d;
   logic              all_valid_q, all_valid_d;

   logic              cap, accept, last_acc, more, restart;
   rows_t             src_rows;
   logic [CNT_W-1:0]  issue_idx;
   logic signed [ACC_WIDTH-1:0] lane_sum [LANES];

   assign all_valid_d = &bus.row_valid;
   assign cap         = all_valid_d & ~all_valid_q;
   assign accept      = res_valid_q & bus.res_ready;
   assign last_acc    = accept & (res_beat_q == BEAT_W'(NUM_BEATS - 1));
   assign more        = beat_q < CNT_W'(NUM_BEATS);
   // Back-to-back restart computes beat 0 straight from the incoming rows, avoiding a bubble.
   assign restart     = (state_q == COMPUTE) & last_acc & cap;
   assign src_rows    = restart ? bus.row_din : rows_q;
   assign issue_idx   = (restart | ~more) ? '0 : beat_q;

   for (genvar l = 0; l < LANES; l++) begin : g_lane
      kern_t win;
      always_comb begin
         int base;
         base = int'(issue_idx) * LANES + l;
         win  = '0;
         for (int r = 0; r < KH; r++) begin
            for (int k = 0; k < KW; k++) begin
               win[r][k] = src_rows[r][IDX_W'(base + k)];
            end
         end
      end

      conv_mac_lane #(
         .DATA_WIDTH (DATA_WIDTH),
         .KH         (KH),
         .KW         (KW),
         .ACC_WIDTH  (ACC_WIDTH)
      ) u_mac (
         .win (win),
         .w   (w_q),
         .sum (lane_sum[l])
      );
   end

   always_comb begin
      logic issue;
      state_d     = state_q;
      rows_d      = rows_q;
      w_d         = w_q;
      res_dout_d  = res_dout_q;
      res_valid_d = res_valid_q;
      res_beat_d  = res_beat_q;
      beat_d      = beat_q;
      done_d      = 1'b0;
      overrun_d   = overrun_q;
      issue       = 1'b0;

      case (state_q)
         IDLE: begin
            if (bus.weight_wen) w_d = bus.weight_din;
            if (cap) begin
               rows_d  = bus.row_din;
               beat_d  = '0;
               state_d = COMPUTE;
            end
         end
         COMPUTE: begin
            if (bus.weight_wen) overrun_d = 1'b1;
            if (last_acc) begin
               done_d = 1'b1;
               if (cap) begin
                  rows_d = bus.row_din;
                  issue  = 1'b1;
               end else begin
                  res_valid_d = 1'b0;
                  state_d     = IDLE;
               end
            end else begin
               if (cap) overrun_d = 1'b1;
               if (more & (~res_valid_q | bus.res_ready)) issue = 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase

      if (issue) begin
         res_valid_d = 1'b1;
         res_beat_d  = restart ? '0 : BEAT_W'(beat_q);
         beat_d      = restart ? CNT_W'(1) : beat_q + CNT_W'(1);
         for (int l = 0; l < LANES; l++) res_dout_d[l] = apply_relu(lane_sum[l]);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= IDLE;
         rows_q      <= '0;
         w_q         <= '0;
         res_dout_q  <= '0;
         res_valid_q <= 1'b0;
         res_beat_q  <= '0;
         beat_q      <= '0;
         done_q      <= 1'b0;
         overrun_q   <= 1'b0;
         all_valid_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         rows_q      <= rows_d;
         w_q         <= w_d;
         res_dout_q  <= res_dout_d;
         res_valid_q <= res_valid_d;
         res_beat_q  <= res_beat_d;
         beat_q      <= beat_d;
         done_q      <= done_d;
         overrun_q   <= overrun_d;
         all_valid_q <= all_valid_d;
      end
   end

   assign bus.res_dout  = res_dout_q;
   assign bus.res_valid = res_valid_q;
   assign bus.res_beat  = res_beat_q;
   assign bus.done      = done_q;
   assign bus.busy      = (state_q != IDLE);
   assign bus.overrun   = overrun_q;
endmodule

// File: tb/tb_conv_row_engine.sv
// Directed bench for conv_row_engine with a window-sum scoreboard built from plain arithmetic.
module tb_conv_row_engine;
   localparam int DW    = 32;
   localparam int DOS   = 128;
   localparam int KH    = 3;
   localparam int KW    = 3;
   localparam int LANES = 14;
   localparam int NOUT  = DOS - KW + 1;
   localparam int NB    = NOUT / LANES;
   localparam int ACCW  = 2 * DW + $clog2(KH * KW);

   logic clk = 1'b0;
   logic rst;

   conv_row_engine_if #(.DATA_WIDTH(DW), .DATA_OF_SET(DOS), .OUT_NUM_OF_SET(KH),
                        .KERNEL_W(KW), .LANES(LANES)) bus ();

   conv_row_engine #(.DATA_WIDTH(DW), .DATA_OF_SET(DOS), .OUT_NUM_OF_SET(KH),
                     .KERNEL_W(KW), .LANES(LANES)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   int     n_tests = 0;
   int     n_fail  = 0;
   int     drv_rows [KH][DOS];
   int     drv_w    [KH][KW];
   int     kw_model [KH][KW];
   longint exp_q [$];
   int     m_beat  = 0;
   int     n_acc   = 0;
   bit     pend_done = 1'b0;

   task automatic chk(input string name, input longint act, input longint exp);
      n_tests++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive_rows();
      for (int r = 0; r < KH; r++)
         for (int i = 0; i < DOS; i++) bus.row_din[r][i] = drv_rows[r][i];
   endtask

   task automatic drive_weights();
      for (int r = 0; r < KH; r++)
         for (int k = 0; k < KW; k++) bus.weight_din[r][k] = drv_w[r][k];
   endtask

   task automatic load_weights();
      drive_weights();
      bus.weight_wen = 1'b1;
      tick();
      bus.weight_wen = 1'b0;
      kw_model = drv_w;
   endtask

   // Expected window sums for the currently driven rows under the model's kernel.
   task automatic push_expect();
      for (int j = 0; j < NOUT; j++) begin
         longint s = 0;
         for (int r = 0; r < KH; r++)
            for (int k = 0; k < KW; k++)
               s += longint'(drv_rows[r][j+k]) * longint'(kw_model[r][k]);
`ifdef CONV_ROW_ENGINE_RELU_EN
         if (s < 0) s = 0;
`endif
         exp_q.push_back(s);
      end
   endtask

   task automatic capture(input bit hold);
      drive_rows();
      bus.row_valid = '1;
      tick();
      if (!hold) bus.row_valid = '0;
   endtask

   task automatic wait_beat(input int b, input string name);
      for (int c = 0; c < 40; c++) begin
         if (bus.res_valid && int'(bus.res_beat) == b) return;
         tick();
      end
      n_tests++;
      n_fail++;
      $display("FAIL %s: beat %0d not seen within 40 cycles", name, b);
   endtask

   task automatic wait_done(input string name, output int cyc);
      cyc = 0;
      for (int c = 0; c < 60; c++) begin
         tick();
         cyc++;
         if (bus.done) return;
      end
      n_tests++;
      n_fail++;
      $display("FAIL %s: done not seen within 60 cycles", name);
   endtask

   // Scoreboard: every valid beat must match the next expected beat; done must follow the last one.
   initial begin
      forever begin
         @(negedge clk);
         if (rst) begin
            exp_q.delete();
            m_beat    = 0;
            pend_done = 1'b0;
         end else begin
            chk("done_pulse", longint'(bus.done), longint'(pend_done));
            pend_done = 1'b0;
            if (bus.res_valid) begin
               n_tests++;
               if (exp_q.size() < LANES) begin
                  n_fail++;
                  $display("FAIL unexpected_beat: got beat %0d, required no beat", bus.res_beat);
               end else begin
                  bit bad = 1'b0;
                  if (int'(bus.res_beat) != m_beat) begin
                     bad = 1'b1;
                     $display("FAIL beat_index: got %0d, expected %0d", bus.res_beat, m_beat);
                  end
                  for (int l = 0; l < LANES; l++) begin
                     if ($signed(bus.res_dout[l]) != ACCW'(exp_q[l])) begin
                        bad = 1'b1;
                        $display("FAIL lane_sum beat %0d lane %0d: got %0d, expected %0d",
                                 m_beat, l, $signed(bus.res_dout[l]), exp_q[l]);
                     end
                  end
                  if (bad) n_fail++;
                  if (bus.res_ready) begin
                     repeat (LANES) void'(exp_q.pop_front());
                     n_acc++;
                     if (m_beat == NB - 1) begin
                        pend_done = 1'b1;
                        m_beat    = 0;
                     end else begin
                        m_beat++;
                     end
                  end
               end
            end
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int cyc;
      int n0;
      longint neg_exp;
      rst            = 1'b1;
      bus.row_din    = '0;
      bus.row_valid  = '0;
      bus.weight_wen = 1'b0;
      bus.weight_din = '0;
      bus.res_ready  = 1'b1;
      for (int r = 0; r < KH; r++) begin
         for (int i = 0; i < DOS; i++) drv_rows[r][i] = 0;
         for (int k = 0; k < KW; k++) begin drv_w[r][k] = 0; kw_model[r][k] = 0; end
      end
      #2;
      chk("rst_valid",   longint'(bus.res_valid), 0);
      chk("rst_beat",    longint'(bus.res_beat), 0);
      chk("rst_done",    longint'(bus.done), 0);
      chk("rst_busy",    longint'(bus.busy), 0);
      chk("rst_overrun", longint'(bus.overrun), 0);
      chk("rst_dout0",   longint'($signed(bus.res_dout[0])), 0);
      chk("rst_dout13",  longint'($signed(bus.res_dout[LANES-1])), 0);
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      tick();

      // Ramp rows, unit kernel, valid held through the run.
      for (int r = 0; r < KH; r++) begin
         for (int i = 0; i < DOS; i++) drv_rows[r][i] = i;
         for (int k = 0; k < KW; k++) drv_w[r][k] = 1;
      end
      load_weights();
      push_expect();
      chk("model_win0", exp_q[0], 9);
      chk("model_win125", exp_q[NOUT-1], 1134);
      n0 = n_acc;
      capture(1'b1);
      chk("busy_after_capture", longint'(bus.busy), 1);
      chk("no_beat_at_capture", longint'(bus.res_valid), 0);
      tick();
      chk("beat0_valid", longint'(bus.res_valid), 1);
      chk("beat0_index", longint'(bus.res_beat), 0);
      chk("beat0_lane0", longint'($signed(bus.res_dout[0])), 9);
      chk("beat0_lane13", longint'($signed(bus.res_dout[13])), 126);
      wait_done("ramp_done", cyc);
      chk("ramp_consecutive", cyc, 9);
      chk("ramp_beats", n_acc - n0, 9);
      repeat (5) tick();
      chk("held_valid_busy", longint'(bus.busy), 0);
      chk("held_valid_res", longint'(bus.res_valid), 0);
      chk("ramp_overrun", longint'(bus.overrun), 0);
      bus.row_valid = '0;
      tick();

      bus.row_valid = 3'b011;
      repeat (4) tick();
      chk("partial_valid_busy", longint'(bus.busy), 0);
      bus.row_valid = '0;
      tick();

      // Mixed-sign data and kernel with a 3-cycle stall on beat 1.
      for (int r = 0; r < KH; r++)
         for (int i = 0; i < DOS; i++) drv_rows[r][i] = i * (r + 1) - 50;
      drv_w[0][0] = 1; drv_w[0][1] = -2; drv_w[0][2] = 3;
      drv_w[1][0] = 0; drv_w[1][1] = 4;  drv_w[1][2] = -1;
      drv_w[2][0] = 2; drv_w[2][1] = 1;  drv_w[2][2] = -3;
      load_weights();
      push_expect();
      n0 = n_acc;
      capture(1'b0);
      tick();
      tick();
      bus.res_ready = 1'b0;
      repeat (3) tick();
      chk("stall_hold_beat", longint'(bus.res_beat), 1);
      chk("stall_hold_valid", longint'(bus.res_valid), 1);
      bus.res_ready = 1'b1;
      wait_done("stall_done", cyc);
      chk("stall_cycles", cyc, 8);
      chk("stall_beats", n_acc - n0, 9);

      // New rows arrive exactly on last-beat acceptance.
      for (int r = 0; r < KH; r++)
         for (int i = 0; i < DOS; i++) drv_rows[r][i] = (i % 7) + r;
      push_expect();
      n0 = n_acc;
      capture(1'b0);
      wait_beat(NB - 1, "restart_last");
      for (int r = 0; r < KH; r++)
         for (int i = 0; i < DOS; i++) drv_rows[r][i] = 3 * r - (i % 5);
      push_expect();
      drive_rows();
      bus.row_valid = '1;
      tick();
      bus.row_valid = '0;
      chk("restart_done", longint'(bus.done), 1);
      chk("restart_busy", longint'(bus.busy), 1);
      chk("restart_valid", longint'(bus.res_valid), 1);
      chk("restart_beat0", longint'(bus.res_beat), 0);
      wait_done("restart_done2", cyc);
      chk("restart_beats", n_acc - n0, 18);

      // Capture while busy is dropped and flagged.
      for (int r = 0; r < KH; r++)
         for (int i = 0; i < DOS; i++) drv_rows[r][i] = i - 2 * r;
      push_expect();
      n0 = n_acc;
      capture(1'b0);
      wait_beat(3, "ovr_beat3");
      for (int r = 0; r < KH; r++)
         for (int i = 0; i < DOS; i++) drv_rows[r][i] = 1000 + i;
      drive_rows();
      bus.row_valid = '1;
      tick();
      bus.row_valid = '0;
      chk("ovr_capture_flag", longint'(bus.overrun), 1);
      chk("ovr_capture_busy", longint'(bus.busy), 1);
      wait_done("ovr_done", cyc);
      chk("ovr_beats", n_acc - n0, 9);
      chk("ovr_sticky", longint'(bus.overrun), 1);

      // Weight load while busy is ignored and flagged.
      #1 rst = 1'b1;
      #1;
      chk("rst_clears_overrun", longint'(bus.overrun), 0);
      tick();
      rst = 1'b0;
      for (int r = 0; r < KH; r++) begin
         for (int k = 0; k < KW; k++) begin kw_model[r][k] = 0; drv_w[r][k] = 2; end
         for (int i = 0; i < DOS; i++) drv_rows[r][i] = i;
      end
      load_weights();
      push_expect();
      chk("model_w2_win1", exp_q[1], 36);
      n0 = n_acc;
      capture(1'b0);
      wait_beat(2, "wovr_beat2");
      for (int r = 0; r < KH; r++)
         for (int k = 0; k < KW; k++) drv_w[r][k] = 7;
      drive_weights();
      bus.weight_wen = 1'b1;
      tick();
      bus.weight_wen = 1'b0;
      chk("wovr_flag", longint'(bus.overrun), 1);
      wait_done("wovr_done", cyc);
      chk("wovr_beats", n_acc - n0, 9);
      chk("queue_drained", longint'(exp_q.size()), 0);

      // Weight load and capture in the same idle cycle, then abort by reset.
      #1 rst = 1'b1;
      tick();
      rst = 1'b0;
      for (int r = 0; r < KH; r++) begin
         for (int k = 0; k < KW; k++) drv_w[r][k] = 0;
         for (int i = 0; i < DOS; i++) drv_rows[r][i] = 5;
      end
      drv_w[1][1] = -1;
      kw_model = drv_w;
      push_expect();
`ifdef CONV_ROW_ENGINE_RELU_EN
      neg_exp = 0;
`else
      neg_exp = -5;
`endif
      chk("model_neg_win0", exp_q[0], neg_exp);
      drive_weights();
      drive_rows();
      bus.weight_wen = 1'b1;
      bus.row_valid  = '1;
      tick();
      bus.weight_wen = 1'b0;
      bus.row_valid  = '0;
      tick();
      chk("neg_lane0", longint'($signed(bus.res_dout[0])), neg_exp);
      wait_beat(4, "abort_beat4");
      #1 rst = 1'b1;
      #1;
      chk("abort_valid",   longint'(bus.res_valid), 0);
      chk("abort_beat",    longint'(bus.res_beat), 0);
      chk("abort_busy",    longint'(bus.busy), 0);
      chk("abort_done",    longint'(bus.done), 0);
      chk("abort_overrun", longint'(bus.overrun), 0);
      chk("abort_dout0",   longint'($signed(bus.res_dout[0])), 0);
      tick();
      rst = 1'b0;
      repeat (5) tick();
      chk("abort_idle_busy", longint'(bus.busy), 0);
      chk("abort_idle_valid", longint'(bus.res_valid), 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
